// File: rtl/intersection_arbiter_if.sv
// Intersection arbiter bus: approach requests and delay settings in, lamp state and grant out.
interface intersection_arbiter_if;
  logic [3:0] req;
  logic [2:0] y2rdelay;
  logic [2:0] r2gdelay;
  logic [7:0] light;
  logic [1:0] grant;
  logic       busy;

  modport master (
    output req, y2rdelay, r2gdelay,
    input  light, grant, busy
  );

  modport slave (
    input  req, y2rdelay, r2gdelay,
    output light, grant, busy
  );
endinterface

// File: rtl/intersection_arbiter.sv
// Four-way traffic-light arbiter: round-robin GREEN grants, YELLOW and ALLRED clearance, registered lamps.
// One-cycle IDLE->GREEN latency; requests are levels and never latched.
module intersection_arbiter #(
  parameter int MIN_GREEN = 2,
  parameter int MAX_GREEN = 8
) (
  input  logic                   clock,
  input  logic                   clear,
  intersection_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

  localparam logic [1:0] YEL_C    = 2'd1;
  localparam logic [1:0] GRN_C    = 2'd2;
  localparam logic [7:0] MIN_LAST = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST = 8'(MAX_GREEN - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] gcnt;
  logic [2:0] dcnt;

  logic [1:0] winner;
  logic       any_req;
  logic       others_req;
  logic       green_done;

  function automatic logic [7:0] lamp(input logic [1:0] idx, input logic [1:0] code);
    lamp = 8'h00;
    lamp[{idx, 1'b0} +: 2] = code;
  endfunction

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner     = rr_pick(bus.req, ptr);
  assign any_req    = |bus.req;
  assign others_req = |(bus.req & ~(4'b0001 << bus.grant));
  assign green_done = (gcnt >= MIN_LAST) &&
                      (!bus.req[bus.grant] || ((gcnt >= MAX_LAST) && others_req));

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      bus.light <= 8'h00;
      bus.grant <= 2'd0;
      bus.busy  <= 1'b0;
      ptr       <= 2'd0;
      gcnt      <= 8'd0;
      dcnt      <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= GREEN;
            bus.grant <= winner;
            ptr       <= winner + 2'd1;
            gcnt      <= 8'd0;
            bus.light <= lamp(winner, GRN_C);
            bus.busy  <= 1'b1;
          end
        end
        GREEN: begin
          if (green_done) begin
            state     <= YELLOW;
            dcnt      <= bus.y2rdelay;
            gcnt      <= 8'd0;
            bus.light <= lamp(bus.grant, YEL_C);
          end else if (gcnt != 8'hFF) begin
            gcnt <= gcnt + 8'd1;
          end
        end
        YELLOW: begin
          if (dcnt == 3'd0) begin
            state     <= ALLRED;
            dcnt      <= bus.r2gdelay;
            bus.light <= 8'h00;
          end else begin
            dcnt <= dcnt - 3'd1;
          end
        end
        ALLRED: begin
          if (dcnt != 3'd0) begin
            dcnt <= dcnt - 3'd1;
          end else if (any_req) begin
            state     <= GREEN;
            bus.grant <= winner;
            ptr       <= winner + 2'd1;
            gcnt      <= 8'd0;
            bus.light <= lamp(winner, GRN_C);
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed scoreboard bench for intersection_arbiter: driver queues hand-computed outputs, monitor checks each cycle.
module tb_intersection_arbiter;

  logic clock;
  logic clear;
  intersection_arbiter_if bus ();

  intersection_arbiter #(.MIN_GREEN(2), .MAX_GREEN(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [10:0] exp_q[$];
  int          id_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          step_no = 0;

  function automatic logic [7:0] lamp(input int a, input logic [1:0] c);
    logic [7:0] v;
    v = 8'(c);
    lamp = v << (2 * a);
  endfunction

  // Apply inputs, let one edge pass, then queue the output expected after that edge.
  task automatic step(input logic [3:0] r, input logic c,
                      input logic [7:0] el, input logic [1:0] eg, input logic eb);
    bus.req = r;
    clear   = c;
    @(posedge clock);
    #1;
    step_no++;
    exp_q.push_back({el, eg, eb});
    id_q.push_back(step_no);
  endtask

  task automatic run(input int n, input logic [3:0] r,
                     input logic [7:0] el, input logic [1:0] eg, input logic eb);
    for (int i = 0; i < n; i++) step(r, 1'b0, el, eg, eb);
  endtask

  initial begin : monitor
    logic [10:0] e;
    int          id;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        checks++;
        if ({bus.light, bus.grant, bus.busy} !== e) begin
          fails++;
          $display("FAIL step%0d light/grant/busy got %h/%0d/%b expected %h/%0d/%b",
                   id, bus.light, bus.grant, bus.busy, e[10:3], e[2:1], e[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.req      = 4'h0;
    bus.y2rdelay = 3'd3;
    bus.r2gdelay = 3'd3;
    clear        = 1'b1;

    // Held in clear with all approaches requesting.
    for (int i = 0; i < 5; i++) step(4'hF, 1'b1, 8'h00, 2'd0, 1'b0);
    run(2, 4'h0, 8'h00, 2'd0, 1'b0);

    // Single requester on N for 6 cycles.
    run(6, 4'h1, 8'h02, 2'd0, 1'b1);
    run(4, 4'h0, 8'h01, 2'd0, 1'b1);
    run(4, 4'h0, 8'h00, 2'd0, 1'b1);
    run(1, 4'h0, 8'h00, 2'd0, 1'b0);

    // S alone holds GREEN indefinitely; delay changes mid-interval are ignored.
    run(20, 4'h4, 8'h20, 2'd2, 1'b1);
    run(1, 4'h0, 8'h10, 2'd2, 1'b1);
    bus.y2rdelay = 3'd0;
    run(3, 4'h0, 8'h10, 2'd2, 1'b1);
    run(1, 4'h0, 8'h00, 2'd2, 1'b1);
    bus.r2gdelay = 3'd7;
    run(3, 4'h0, 8'h00, 2'd2, 1'b1);
    run(1, 4'h0, 8'h00, 2'd2, 1'b0);
    bus.y2rdelay = 3'd3;
    bus.r2gdelay = 3'd3;

    // One-cycle pulse on E: ptr is 3, so E wins; MIN_GREEN keeps it 2 cycles.
    run(1, 4'h2, 8'h08, 2'd1, 1'b1);
    run(1, 4'h0, 8'h08, 2'd1, 1'b1);
    run(4, 4'h0, 8'h04, 2'd1, 1'b1);
    run(4, 4'h0, 8'h00, 2'd1, 1'b1);
    run(1, 4'h0, 8'h00, 2'd1, 1'b0);

    // Full load from a cleared pointer: 0,1,2,3,0,1 each 8 GREEN, 4 YELLOW, 4 ALLRED.
    step(4'hF, 1'b1, 8'h00, 2'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run(8, 4'hF, lamp(k % 4, 2'd2), 2'(k % 4), 1'b1);
      run(4, 4'hF, lamp(k % 4, 2'd1), 2'(k % 4), 1'b1);
      run(4, 4'hF, 8'h00, 2'(k % 4), 1'b1);
    end

    // Clear mid-GREEN of S drops straight to all RED; pointer restarts at N.
    run(3, 4'hF, 8'h20, 2'd2, 1'b1);
    step(4'hF, 1'b1, 8'h00, 2'd0, 1'b0);
    run(3, 4'hF, 8'h02, 2'd0, 1'b1);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
